mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: DW, 8, operand width per requester; result width is DW+3.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clk is the clock and rst is the reset, active low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 req  input  4  per-requester request; bit i = requester i.
REQ-006 din  input  4*DW  packed operands; requester i at din[DW*i+DW-1 : DW*i].
REQ-007 grant  output  4  registered one-hot grant; pulses for the cycle after operand capture.
REQ-008 busy  output  1  high while an operation is in progress (state P0..P3).
REQ-009 out  output  DW+3  registered result.
REQ-010 out_valid  output  1  registered; qualifies out.
REQ-011 out_id  output  2  requester index that owns out.
REQ-012 out_phase  output  2  coefficient index of out: 0 = x1, 1 = x3, 2 = x7, 3 = x8.

Function
REQ-013 The FSM SHALL have states IDLE, P0, P1, P2 and P3; busy = (state != IDLE), decoded from the state register.
REQ-014 Arbitration point: any rising edge with state IDLE, or with state P3.
- If req != 0, the block SHALL select a winner w by round-robin, searching last_id+1, +2, +3, +4 (mod 4).
REQ-015 On an arbitration edge with a winner, the block SHALL:
- capture d_reg <= din[w];
- set cur_id <= w and last_id <= w;
- set grant <= onehot(w);
- set state <= P0.
REQ-016 On an arbitration edge with req == 0, state SHALL go to IDLE.
REQ-017 grant SHALL be 0 at every edge that does not capture an operand, so each grant pulse lasts exactly one cycle.
REQ-018 Each edge leaving Pk SHALL register:
- out <= d_reg * C[k], with C = {1, 3, 7, 8};
- out_valid <= 1, out_phase <= k, out_id <= cur_id.
- Then P0 -> P1 -> P2 -> P3, and P3 behaves as an arbitration point (REQ-014).
REQ-019 Coefficients SHALL be built by shift-add only, all zero-extended to DW+3 bits with no truncation:
- x3 = d + (d<<1);
- x7 = d + (d<<1) + (d<<2);
- x8 = d<<3.
REQ-020 Latency: the capture edge is E0; results x1, x3, x7, x8 appear after E1, E2, E3, E4.
REQ-021 Throughput: one operation per 4 cycles with back-to-back requests.
- With back-to-back requests out_valid SHALL stay continuously high.
- The next operand is captured at E4.
REQ-022 At an edge leaving IDLE with no capture, out_valid SHALL be 0 and out, out_id and out_phase SHALL hold their last values.
REQ-023 Request rules:
- A requester SHALL hold req and din stable until it sees its grant bit.
- It SHALL drop req within 3 cycles of the grant, or the request counts as a new one.
- Changes to req or din outside arbitration edges SHALL have no effect.
REQ-024 Simultaneous requests SHALL resolve strictly by the round-robin order; no requester waits more than 3 other operations.

Reset
REQ-025 While rst = 0, the block SHALL immediately force:
- state = IDLE;
- grant = 0, busy = 0;
- out = 0, out_valid = 0, out_id = 0, out_phase = 0;
- d_reg = 0, cur_id = 0, last_id = 3, so requester 0 has first priority.
REQ-026 Reset asserted mid-operation SHALL abort the operation: no further results for it, and it is not replayed.
REQ-027 The first arbitration after reset release SHALL occur at the first rising edge with rst = 1.

Verification
REQ-028 Reset: assert rst = 0 mid-P2 -> all outputs 0 immediately; after release with req = 4'b1111, grant = 4'b0001 first.
REQ-029 Single request: req = 4'b0010, din[15:8] = 5 -> grant = 4'b0010 for 1 cycle; out = 5, 15, 35, 40 with out_id = 1 and out_phase = 0..3; then out_valid = 0.
REQ-030 Max operand: req = 4'b0001, din[7:0] = 255 -> out = 255, 765, 1785, 2040, no overflow.
REQ-031 All requests held (din = 1, 2, 3, 4 for requesters 0..3) -> grants in order 0, 1, 2, 3, 0; out_valid high continuously for 16+ cycles; out_id follows.
REQ-032 Fairness: req1 granted; during P1 raise req0 and keep req1 high -> next grant 4'b0001, then 4'b0010.
REQ-033 Idle gap: req drops to 0 at E4 -> state IDLE, busy = 0, out holds 40, out_valid = 0; a later req restarts from P0.

Source files
------------

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - four-requester round-robin arbiter feeding a shift-add x1/x3/x7/x8 multiplier
module mult_arbiter #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] din,
  output logic [3:0]      grant,
  output logic            busy,
  output logic [DW+2:0]   out,
  output logic            out_valid,
  output logic [1:0]      out_id,
  output logic [1:0]      out_phase
);

  localparam int OW = DW + 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4
  } state_t;

  state_t        state;
  logic [DW-1:0] d_reg;
  logic [1:0]    cur_id;
  logic [1:0]    last_id;

  logic          found;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic [OW-1:0] d_ext;
  logic [OW-1:0] x3;
  logic [OW-1:0] x7;
  logic [OW-1:0] x8;
  logic [OW-1:0] prod;
  logic [1:0]    phase;

  assign busy = (state != IDLE);

  // Round-robin search starting just after the last winner
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_id + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Shift-add coefficients on the zero-extended operand, then pick by phase
  always_comb begin
    d_ext = {3'b000, d_reg};
    x3    = d_ext + (d_ext << 1);
    x7    = x3 + (d_ext << 2);
    x8    = d_ext << 3;
    prod  = d_ext;
    phase = 2'd0;
    case (state)
      P0: begin prod = d_ext; phase = 2'd0; end
      P1: begin prod = x3;    phase = 2'd1; end
      P2: begin prod = x7;    phase = 2'd2; end
      P3: begin prod = x8;    phase = 2'd3; end
      default: begin prod = d_ext; phase = 2'd0; end
    endcase
  end

  // Sequencer: arbitrate in IDLE/P3, emit one product per phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= 4'b0000;
      out       <= '0;
      out_valid <= 1'b0;
      out_id    <= 2'd0;
      out_phase <= 2'd0;
      d_reg     <= '0;
      cur_id    <= 2'd0;
      last_id   <= 2'd3;
    end else begin
      grant <= 4'b0000;
      if (state != IDLE) begin
        out       <= prod;
        out_valid <= 1'b1;
        out_phase <= phase;
        out_id    <= cur_id;
      end else begin
        out_valid <= 1'b0;
      end
      case (state)
        P0: state <= P1;
        P1: state <= P2;
        P2: state <= P3;
        default: begin
          if (found) begin
            d_reg   <= din[DW*win +: DW];
            cur_id  <= win;
            last_id <= win;
            grant   <= 4'b0001 << win;
            state   <= P0;
          end else begin
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed vector bench for mult_arbiter
module tb_mult_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  grant;
  logic        busy;
  logic [10:0] out;
  logic        out_valid;
  logic [1:0]  out_id;
  logic [1:0]  out_phase;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]       req;
    logic [31:0]      din;
    logic [1:0]       id;
    logic [3:0][10:0] x;
  } vec_t;

  vec_t vecs[5];
  int   coef[4];

  mult_arbiter #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .grant     (grant),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_phase (out_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d, input logic [1:0] id,
                              input int a, input int b, input int c, input int e);
    vec_t v;
    v.req  = r;
    v.din  = d;
    v.id   = id;
    v.x[0] = 11'(a);
    v.x[1] = 11'(b);
    v.x[2] = 11'(c);
    v.x[3] = 11'(e);
    return v;
  endfunction

  initial begin
    coef[0] = 1; coef[1] = 3; coef[2] = 7; coef[3] = 8;
    vecs[0] = mk(4'b0010, 32'h0000_0500, 2'd1,   5,  15,   35,   40);
    vecs[1] = mk(4'b0001, 32'h0000_00FF, 2'd0, 255, 765, 1785, 2040);
    vecs[2] = mk(4'b1000, 32'h8011_2233, 2'd3, 128, 384,  896, 1024);
    vecs[3] = mk(4'b0100, 32'hAA2A_BBCC, 2'd2,  42, 126,  294,  336);
    vecs[4] = mk(4'b0001, 32'h0000_0001, 2'd0,   1,   3,    7,    8);

    rst = 1'b0;
    req = 4'b0000;
    din = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_id", out_id, 0);
    chk("rst_phase", out_phase, 0);
    rst = 1'b1;

    // Single operations from IDLE, then an idle cycle
    for (int v = 0; v < 5; v++) begin
      req = vecs[v].req;
      din = vecs[v].din;
      @(negedge clk);
      chk("vec_grant", grant, vecs[v].req);
      chk("vec_busy", busy, 1);
      chk("vec_valid_e0", out_valid, 0);
      req = 4'b0000;
      din = 32'hDEAD_BEEF;
      for (int ph = 0; ph < 4; ph++) begin
        @(negedge clk);
        chk("vec_out", out, vecs[v].x[ph]);
        chk("vec_valid", out_valid, 1);
        chk("vec_id", out_id, vecs[v].id);
        chk("vec_phase", out_phase, ph);
        chk("vec_grant_low", grant, 0);
      end
      chk("vec_busy_end", busy, 0);
      @(negedge clk);
      chk("idle_valid", out_valid, 0);
      chk("idle_out_hold", out, vecs[v].x[3]);
      chk("idle_id_hold", out_id, vecs[v].id);
      chk("idle_busy", busy, 0);
    end

    // Reset asserted mid-P2 aborts the operation
    req = 4'b0100;
    din = 32'h0007_0000;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    chk("pre_rst_out1", out, 7);
    @(negedge clk);
    chk("pre_rst_out3", out, 21);
    rst = 1'b0;
    req = 4'b1111;
    din = 32'h0403_0201;
    #1;
    chk("async_rst_out", out, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_id", out_id, 0);
    chk("async_rst_phase", out_phase, 0);
    chk("async_rst_grant", grant, 0);
    @(negedge clk);
    chk("held_rst_busy", busy, 0);
    chk("held_rst_grant", grant, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", grant, 4'b0001);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_busy", busy, 1);

    // All requesters held: round-robin 0,1,2,3,0 with continuous valid
    for (int op = 0; op < 4; op++) begin
      for (int ph = 0; ph < 4; ph++) begin
        @(negedge clk);
        chk("rr_out", out, (op + 1) * coef[ph]);
        chk("rr_valid", out_valid, 1);
        chk("rr_id", out_id, op);
        chk("rr_phase", out_phase, ph);
        if (ph == 3) chk("rr_grant", grant, 4'b0001 << ((op + 1) % 4));
        else         chk("rr_grant_low", grant, 0);
      end
    end
    req = 4'b0000;
    for (int ph = 0; ph < 4; ph++) begin
      @(negedge clk);
      chk("rr_tail_out", out, coef[ph]);
      chk("rr_tail_valid", out_valid, 1);
      chk("rr_tail_id", out_id, 0);
    end
    @(negedge clk);
    chk("rr_end_valid", out_valid, 0);
    chk("rr_end_busy", busy, 0);

    // Fairness: req0 raised during P1 of requester 1 wins next
    req = 4'b0010;
    din = 32'h0000_0509;
    @(negedge clk);
    chk("fair_grant1", grant, 4'b0010);
    @(negedge clk);
    chk("fair_out1", out, 5);
    req = 4'b0011;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("fair_out_last", out, 40);
    chk("fair_grant0", grant, 4'b0001);
    @(negedge clk);
    chk("fair_out_r0", out, 9);
    chk("fair_id_r0", out_id, 0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("fair_out_r0_x8", out, 72);
    chk("fair_grant_again", grant, 4'b0010);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("fair_final_out", out, 40);
    chk("fair_final_id", out_id, 1);
    chk("fair_final_busy", busy, 0);
    @(negedge clk);
    chk("fair_final_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
